// File: rtl/fetch_inst_queue_pkg.sv
// Shared types and default widths for the fetch-to-decode instruction queue.
// Contents:
//   FETCH_WIDTH   - default number of enqueue lanes
//   DECODE_WIDTH  - default number of dequeue lanes
//   fetch_entry_t - payload stored per queue slot
package fetch_inst_queue_pkg;

   localparam int unsigned FETCH_WIDTH  = 4;
   localparam int unsigned DECODE_WIDTH = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_inst_queue_lane_compactor.sv
// Combinational prefix popcount over a sparse lane-valid vector.
// Ports:
//   i_vld    - per-lane valid
//   o_offset - per-lane count of set lanes strictly below it (compacted write offset)
//   o_count  - total number of set lanes
module lane_compactor #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] i_vld,
   output logic [CNT_W-1:0] o_offset [WIDTH],
   output logic [CNT_W-1:0] o_count
);

   logic [CNT_W-1:0] acc;

   always_comb begin
      acc = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         o_offset[i] = acc;
         acc         = acc + CNT_W'(i_vld[i]);
      end
      o_count = acc;
   end

endmodule

// File: rtl/fetch_inst_queue.sv
// Fetch-to-decode instruction queue. Compacts sparse fetch packets into a circular buffer of
// any DEPTH and presents up to OUT_WIDTH oldest entries to decode, which consumes a prefix.
// Ports:
//   clk, rst          - clock, synchronous active-low reset
//   i_flush           - squash; empties the queue (perf counter kept)
//   o_can_enq/o_stall - room for a full IN_WIDTH packet (plus margin) / its inverse
//   i_enq_vld/data    - sparse enqueue lanes
//   o_deq_vld/data    - head+0..head+OUT_WIDTH-1 and their validity
//   i_deq_req         - decode consume request; only the leading run of ones counts
//   o_count           - occupancy
//   o_perf_stall_cnt  - saturating count of cycles fetch was back-pressured
module fetch_inst_queue
   import fetch_inst_queue_pkg::*;
#(
   parameter type         dtype      = fetch_entry_t,
   parameter int unsigned IN_WIDTH   = FETCH_WIDTH,
   parameter int unsigned OUT_WIDTH  = DECODE_WIDTH,
   parameter int unsigned DEPTH      = 24,
   parameter int unsigned ENQ_MARGIN = 0,
   parameter int unsigned PERF_W     = 32,
   parameter int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_flush,
   output logic                 o_can_enq,
   output logic                 o_stall,
   input  logic [IN_WIDTH-1:0]  i_enq_vld,
   input  dtype                 i_enq_data [IN_WIDTH],
   output logic [OUT_WIDTH-1:0] o_deq_vld,
   input  logic [OUT_WIDTH-1:0] i_deq_req,
   output dtype                 o_deq_data [OUT_WIDTH],
   output logic [CNT_W-1:0]     o_count,
   output logic [PERF_W-1:0]    o_perf_stall_cnt
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned OFF_W = $clog2(IN_WIDTH + 1);
   localparam int unsigned DEQ_W = $clog2(OUT_WIDTH + 1);
   // Highest occupancy at which a full packet plus margin still fits.
   localparam logic [CNT_W-1:0] ENQ_LIMIT = CNT_W'(DEPTH - IN_WIDTH - ENQ_MARGIN);

   // Modular add without a power-of-two depth; n never exceeds DEPTH.
   function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] ptr,
                                                input int unsigned n);
      int unsigned sum;
      sum = 32'(ptr) + n;
      if (sum >= DEPTH) sum = sum - DEPTH;
      return PTR_W'(sum);
   endfunction

   function automatic logic [DEQ_W-1:0] lead_ones(input logic [OUT_WIDTH-1:0] v);
      logic [DEQ_W-1:0] n;
      logic             run;
      n   = '0;
      run = 1'b1;
      for (int k = 0; k < int'(OUT_WIDTH); k++) begin
         if (run && v[k]) n = n + DEQ_W'(1);
         else             run = 1'b0;
      end
      return n;
   endfunction

   logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [PERF_W-1:0] perf_q, perf_d;
   dtype              mem_q [DEPTH];

   logic              can_enq, enq_fire;
   logic [OFF_W-1:0]  lane_off [IN_WIDTH];
   logic [OFF_W-1:0]  enq_pop, enq_n;
   logic [DEQ_W-1:0]  deq_n;
   logic [PTR_W-1:0]  wr_idx [IN_WIDTH];

   lane_compactor #(
      .WIDTH (IN_WIDTH),
      .CNT_W (OFF_W)
   ) u_compactor (
      .i_vld    (i_enq_vld),
      .o_offset (lane_off),
      .o_count  (enq_pop)
   );

   // Gated on registered occupancy only, so same-cycle dequeue never frees room.
   assign can_enq   = (count_q <= ENQ_LIMIT);
   assign enq_fire  = can_enq && !i_flush;
   assign o_can_enq = can_enq;
   assign o_stall   = !can_enq;
   assign o_count   = count_q;
   assign o_perf_stall_cnt = perf_q;

   always_comb begin
      for (int l = 0; l < int'(IN_WIDTH); l++) begin
         wr_idx[l] = ptr_add(tail_q, 32'(lane_off[l]));
      end
      for (int k = 0; k < int'(OUT_WIDTH); k++) begin
         o_deq_vld[k]  = (count_q > CNT_W'(k));
         o_deq_data[k] = mem_q[ptr_add(head_q, k)];
      end
   end

   always_comb begin
      enq_n   = enq_fire ? enq_pop : '0;
      deq_n   = i_flush ? '0 : lead_ones(i_deq_req & o_deq_vld);
      head_d  = ptr_add(head_q, 32'(deq_n));
      tail_d  = ptr_add(tail_q, 32'(enq_n));
      count_d = count_q + CNT_W'(enq_n) - CNT_W'(deq_n);
      if (i_flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
      perf_d = perf_q;
      if ((|i_enq_vld) && !can_enq && !i_flush && (perf_q != '1)) begin
         perf_d = perf_q + PERF_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         perf_q  <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         perf_q  <= perf_d;
      end
   end

   // Storage carries no reset; validity is tracked by count_q alone.
   always_ff @(posedge clk) begin
      for (int l = 0; l < int'(IN_WIDTH); l++) begin
         if (enq_fire && i_enq_vld[l]) mem_q[wr_idx[l]] <= i_enq_data[l];
      end
   end

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (rst) begin
         assert (count_q <= CNT_W'(DEPTH)) else $error("occupancy exceeds depth");
         if ((i_deq_req & ~o_deq_vld) != '0) $warning("deq request beyond valid entries");
      end
   end
`endif

endmodule

// File: doc/fetch_inst_queue.md
Name: fetch_inst_queue

Overview:
- Parametrised successor of the fetch-to-decode instruction buffer.
- Accepts sparse multi-lane fetch packets and compacts valid lanes in lane order.
- Delivers up to OUT_WIDTH entries in order to decode, which consumes a contiguous prefix of them.
- Adds beyond the previous buffer: any DEPTH (non-power-of-two), free-space margin for enqueue back-pressure, occupancy output, saturating stall-cycle performance counter; squash flushes it.

Parameters:
- dtype, fetchEntry_t, entry type stored per slot.
- IN_WIDTH, `FETCH_WIDTH, enqueue lanes.
- OUT_WIDTH, `DECODE_WIDTH, dequeue lanes.
- DEPTH, 24, entries; any integer >= max(IN_WIDTH, OUT_WIDTH) + ENQ_MARGIN.
- ENQ_MARGIN, 0, extra free slots required before enqueue is allowed.
- PERF_W, 32, stall counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- i_flush  in  1  squash; clears queue.
- o_can_enq  out  1  queue can accept a full IN_WIDTH packet this cycle.
- o_stall  out  1  equals !o_can_enq; to fetch.
- i_enq_vld  in  IN_WIDTH  per-lane valid, may be sparse.
- i_enq_data  in  dtype[IN_WIDTH]  lane payloads.
- o_deq_vld  out  OUT_WIDTH  bit k set when occupancy > k.
- i_deq_req  in  OUT_WIDTH  decode consume request.
- o_deq_data  out  dtype[OUT_WIDTH]  entries head+0..head+OUT_WIDTH-1.
- o_count  out  $clog2(DEPTH+1)  current occupancy.
- o_perf_stall_cnt  out  PERF_W  cycles with i_enq_vld!=0 and !o_can_enq.

Behaviour:
- State: head and tail pointers in 0..DEPTH-1, count in 0..DEPTH, storage array, perf counter. All are registered.
- Reset (rst==0 at posedge): head=tail=count=0, perf=0. Hence o_deq_vld=0, o_count=0, o_can_enq=1, o_stall=0. Storage contents are don't-care, and o_deq_data is don't-care while not valid.
- o_can_enq is combinational from the count register only: (DEPTH - count) >= IN_WIDTH + ENQ_MARGIN. It does not depend on same-cycle dequeue.
- Enqueue, all-or-nothing:
  - Enqueue happens when o_can_enq && !i_flush.
  - enq_n = popcount(i_enq_vld).
  - The j-th set lane, counted from lane 0, is written to slot (tail + j) mod DEPTH.
  - When !o_can_enq, nothing is written; fetch holds its packet.
- Dequeue:
  - deq_n = number of leading ones of (i_deq_req & o_deq_vld), starting at bit 0.
  - Request bits after the first zero are ignored.
  - head advances by deq_n.
- Pointer advance: ptr_next = ptr + n, minus DEPTH when the sum is >= DEPTH. No power-of-two requirement.
- Occupancy: count_next = count + enq_n - deq_n. Enqueue and dequeue in the same cycle are both honoured.
- Latency: an entry enqueued in cycle t is first visible on o_deq_* in cycle t+1. There is no bypass, including when the queue is empty.
- o_deq_data[k] = storage[(head + k) mod DEPTH], read combinationally from registered head.
- Flush:
  - i_flush==1 sets head=tail=count=0 next cycle.
  - Enqueue and dequeue in that cycle are discarded; decode must treat that cycle's dequeue as squashed.
  - The perf counter is not cleared.
  - Flush while full or empty behaves identically.
  - Reset has priority over flush.
- Full boundary: count never exceeds DEPTH. This is guaranteed by the o_can_enq rule, so no overflow checking is needed.
- Empty boundary: o_deq_vld=0 and deq_n=0 regardless of i_deq_req.
- Perf counter: increments when |i_enq_vld && !o_can_enq && !i_flush; it saturates at all-ones.
- Assertions (sim only):
  - count <= DEPTH.
  - A set i_deq_req bit above a cleared o_deq_vld bit is flagged as a warning, not an error.

Decomposition:
- Shared package (core_define.svh): fetchEntry_t, `FETCH_WIDTH, `DECODE_WIDTH.
- Local functions: the modular-add helper and the leading-ones count.
- Sub-module lane_compactor: combinational prefix-popcount generating a per-lane write offset and enq_n. It is reused later by rename and dispatch compaction.

Test Plan:
- Reset then idle: rst low 2 cycles -> o_count=0, o_deq_vld=0, o_can_enq=1, perf=0.
- Sparse enqueue, IN=OUT=4, DEPTH=24: enqueue i_enq_vld=4'b1010 with data A(lane1), C(lane3), no deq -> next cycle o_count=2, o_deq_vld=4'b0011, o_deq_data[0]=A, [1]=C.
- Prefix dequeue: count=5, i_deq_req=4'b1101 -> deq_n=1; next cycle count=4 and the former entry 1 is at o_deq_data[0].
- Full/back-pressure with ENQ_MARGIN=2:
  - Fill to count=18 -> o_can_enq=1 (free 6 >= 6).
  - Enqueue 4 more -> count=22, o_can_enq=0, o_stall=1.
  - Hold i_enq_vld=4'hF for 3 cycles with no deq -> count stays 22, perf=3.
- Wrap-around, DEPTH=24:
  - Start with head=22, tail=22.
  - Enqueue 4 -> tail=2; dequeue 3 -> head=1.
  - Data order preserved across slots 22, 23, 0, 1.
- Flush with simultaneous enq/deq: count=10, i_flush=1 with i_enq_vld=4'hF and i_deq_req=4'hF -> next cycle count=0, o_deq_vld=0, perf unchanged. Then enqueue 1 entry -> visible the cycle after.
